tcounter_b: RTL and testbench

//  Timer counter stage fed by the timer prescaler block (tprescaler_b).
//  - Advances one step per prescaler tick, in sawtooth-up, sawtooth-down or triangle (up/down) mode.
//  - Shadowed start/end bounds; pulses end_o once per completed period.
//  - Drives the compare/PWM stage downstream.

---
 rtl/tcounter_b_pkg.sv | 34 +++
 rtl/tcounter_b_shadow.sv | 83 ++++++++
 rtl/tcounter_b.sv | 166 ++++++++++++++++
 tb/tb_tcounter_b.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcounter_b_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tcounter_b_pkg                                           |
// | Brief   : Shared types and helpers for the tcounter_b timer stage  |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package tcounter_b_pkg;

  localparam int c_mode_w = 2;

  // Counting mode; RSVD behaves exactly like UP.
  typedef enum logic [c_mode_w-1:0] {
    UP     = 2'b00,
    DOWN   = 2'b01,
    UPDOWN = 2'b10,
    RSVD   = 2'b11
  } tcounter_b_mode_e;

  // Where a (re)started period begins and which way it first moves.
  typedef struct packed {
    logic origin_is_end;  // 1: origin is the end bound, 0: the start bound
    logic dir_down;       // initial direction, 1 = counting down
  } tcounter_b_init_t;

  // Only pure down-counting starts from the end bound and moves downwards.
  function automatic tcounter_b_init_t mode_init(input tcounter_b_mode_e mode);
    tcounter_b_init_t w_init;
    w_init.origin_is_end = (mode == DOWN);
    w_init.dir_down      = (mode == DOWN);
    return w_init;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tcounter_b_shadow.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tcounter_b_shadow                                        |
// | Brief   : Staging + shadow bound/mode registers, pending flag and  |
// |           apply strobe for the tcounter_b timer stage              |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tcounter_b_shadow
  import tcounter_b_pkg::*;
#(
  parameter int NUM_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_ctrl_active,
  input  logic                i_ctrl_update,
  input  logic                i_ctrl_rst,
  input  logic                i_tick,
  input  logic                i_period_done,
  input  logic [NUM_BITS-1:0] i_cfg_start,
  input  logic [NUM_BITS-1:0] i_cfg_end,
  input  logic [1:0]          i_cfg_mode,
  output logic [NUM_BITS-1:0] o_shadow_start,
  output logic [NUM_BITS-1:0] o_shadow_end,
  output tcounter_b_mode_e    o_shadow_mode,
  output logic [NUM_BITS-1:0] o_stage_start,
  output logic [NUM_BITS-1:0] o_stage_end,
  output tcounter_b_mode_e    o_stage_mode,
  output logic                o_apply,
  output logic                o_pending
);

  logic [NUM_BITS-1:0] r_stage_start;
  logic [NUM_BITS-1:0] r_stage_end;
  tcounter_b_mode_e    r_stage_mode;
  logic [NUM_BITS-1:0] r_shadow_start;
  logic [NUM_BITS-1:0] r_shadow_end;
  tcounter_b_mode_e    r_shadow_mode;
  logic                r_pending;
  logic                w_apply;

  // A pending update lands at once while stopped, or on the period-completing
  // tick while running; a counter restart in the same cycle defers it.
  assign w_apply = r_pending & ~i_ctrl_rst &
                   (~i_ctrl_active | (i_tick & i_period_done));

  // Staging/shadow registers; a new request in the apply cycle re-arms pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage_start  <= '0;
      r_stage_end    <= '0;
      r_stage_mode   <= UP;
      r_shadow_start <= '0;
      r_shadow_end   <= '0;
      r_shadow_mode  <= UP;
      r_pending      <= 1'b0;
    end else begin
      if (w_apply) begin
        r_shadow_start <= r_stage_start;
        r_shadow_end   <= r_stage_end;
        r_shadow_mode  <= r_stage_mode;
        r_pending      <= 1'b0;
      end
      if (i_ctrl_update) begin
        r_stage_start <= i_cfg_start;
        r_stage_end   <= i_cfg_end;
        r_stage_mode  <= tcounter_b_mode_e'(i_cfg_mode);
        r_pending     <= 1'b1;
      end
    end
  end

  assign o_shadow_start = r_shadow_start;
  assign o_shadow_end   = r_shadow_end;
  assign o_shadow_mode  = r_shadow_mode;
  assign o_stage_start  = r_stage_start;
  assign o_stage_end    = r_stage_end;
  assign o_stage_mode   = r_stage_mode;
  assign o_apply        = w_apply;
  assign o_pending      = r_pending;

endmodule
`default_nettype wire

// File: rtl/tcounter_b.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tcounter_b                                               |
// | Brief   : Timer counter stage (sawtooth up/down, triangle) driven  |
// |           by prescaler ticks, with shadowed bounds and end pulse   |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tcounter_b
  import tcounter_b_pkg::*;
#(
  parameter int NUM_BITS = 16
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                ctrl_active_i,
  input  logic                ctrl_update_i,
  input  logic                ctrl_rst_i,
  input  logic [NUM_BITS-1:0] cfg_start_i,
  input  logic [NUM_BITS-1:0] cfg_end_i,
  input  logic [1:0]          cfg_mode_i,
  input  logic                tick_i,
  output logic [NUM_BITS-1:0] counter_o,
  output logic                dir_o,
  output logic                end_o,
  output logic                upd_pending_o
);

  localparam logic [NUM_BITS-1:0] c_one = {{(NUM_BITS-1){1'b0}}, 1'b1};

  logic [NUM_BITS-1:0] w_sh_start;
  logic [NUM_BITS-1:0] w_sh_end;
  tcounter_b_mode_e    w_sh_mode;
  logic [NUM_BITS-1:0] w_st_start;
  logic [NUM_BITS-1:0] w_st_end;
  tcounter_b_mode_e    w_st_mode;
  logic                w_apply;
  logic                w_pending;
  logic                w_period_done;
  tcounter_b_init_t    w_init_cur;
  tcounter_b_init_t    w_init_new;

  logic [NUM_BITS-1:0] r_counter;
  logic                r_dir;
  logic                r_end;
  logic [NUM_BITS-1:0] w_counter_nxt;
  logic                w_dir_nxt;
  logic                w_end_nxt;

  tcounter_b_shadow #(
    .NUM_BITS (NUM_BITS)
  ) u_shadow (
    .clk            (clk_i),
    .rst_n          (rstn_i),
    .i_ctrl_active  (ctrl_active_i),
    .i_ctrl_update  (ctrl_update_i),
    .i_ctrl_rst     (ctrl_rst_i),
    .i_tick         (tick_i),
    .i_period_done  (w_period_done),
    .i_cfg_start    (cfg_start_i),
    .i_cfg_end      (cfg_end_i),
    .i_cfg_mode     (cfg_mode_i),
    .o_shadow_start (w_sh_start),
    .o_shadow_end   (w_sh_end),
    .o_shadow_mode  (w_sh_mode),
    .o_stage_start  (w_st_start),
    .o_stage_end    (w_st_end),
    .o_stage_mode   (w_st_mode),
    .o_apply        (w_apply),
    .o_pending      (w_pending)
  );

  assign w_init_cur = mode_init(w_sh_mode);
  assign w_init_new = mode_init(w_st_mode);

  // Does the current count sit on the step that closes a period?
  always_comb begin
    w_period_done = 1'b0;
    if (w_sh_start == w_sh_end) begin
      w_period_done = 1'b1;
    end else begin
      case (w_sh_mode)
        DOWN:    w_period_done = (r_counter == w_sh_start);
        UPDOWN:  w_period_done = r_dir && (r_counter == w_sh_start);
        default: w_period_done = (r_counter == w_sh_end);
      endcase
    end
  end

  // Next counter/direction/end: restart beats apply, apply beats a plain tick.
  always_comb begin
    w_counter_nxt = r_counter;
    w_dir_nxt     = r_dir;
    w_end_nxt     = 1'b0;
    if (ctrl_rst_i) begin
      w_counter_nxt = w_init_cur.origin_is_end ? w_sh_end : w_sh_start;
      w_dir_nxt     = w_init_cur.dir_down;
    end else if (w_apply) begin
      w_counter_nxt = w_init_new.origin_is_end ? w_st_end : w_st_start;
      w_dir_nxt     = w_init_new.dir_down;
      // While running, apply only happens on the period-completing tick.
      w_end_nxt     = ctrl_active_i;
    end else if (ctrl_active_i && tick_i) begin
      if (w_sh_start == w_sh_end) begin
        w_counter_nxt = w_sh_start;
        w_end_nxt     = 1'b1;
      end else begin
        case (w_sh_mode)
          DOWN: begin
            if (r_counter == w_sh_start) begin
              w_counter_nxt = w_sh_end;
              w_end_nxt     = 1'b1;
            end else begin
              w_counter_nxt = r_counter - c_one;
            end
          end
          UPDOWN: begin
            if (!r_dir) begin
              if (r_counter == w_sh_end) begin
                w_dir_nxt     = 1'b1;
                w_counter_nxt = r_counter - c_one;
              end else begin
                w_counter_nxt = r_counter + c_one;
              end
            end else begin
              if (r_counter == w_sh_start) begin
                w_dir_nxt     = 1'b0;
                w_counter_nxt = r_counter + c_one;
                w_end_nxt     = 1'b1;
              end else begin
                w_counter_nxt = r_counter - c_one;
              end
            end
          end
          default: begin
            if (r_counter == w_sh_end) begin
              w_counter_nxt = w_sh_start;
              w_end_nxt     = 1'b1;
            end else begin
              w_counter_nxt = r_counter + c_one;
            end
          end
        endcase
      end
    end
  end

  // Registered counter state; every output comes straight from a flop.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_counter <= '0;
      r_dir     <= 1'b0;
      r_end     <= 1'b0;
    end else begin
      r_counter <= w_counter_nxt;
      r_dir     <= w_dir_nxt;
      r_end     <= w_end_nxt;
    end
  end

  assign counter_o     = r_counter;
  assign dir_o         = r_dir;
  assign end_o         = r_end;
  assign upd_pending_o = w_pending;

endmodule
`default_nettype wire

// File: tb/tb_tcounter_b.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_tcounter_b                                            |
// | Brief   : Self-checking bench for tcounter_b (scoreboard queue)    |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_tcounter_b;

  localparam int NB = 16;

  logic          clk_i         = 1'b0;
  logic          rstn_i        = 1'b1;
  logic          ctrl_active_i = 1'b0;
  logic          ctrl_update_i = 1'b0;
  logic          ctrl_rst_i    = 1'b0;
  logic [NB-1:0] cfg_start_i   = '0;
  logic [NB-1:0] cfg_end_i     = '0;
  logic [1:0]    cfg_mode_i    = '0;
  logic          tick_i        = 1'b0;
  logic [NB-1:0] counter_o;
  logic          dir_o;
  logic          end_o;
  logic          upd_pending_o;

  // Observation word: {counter, dir, end, pending}
  typedef logic [NB+2:0] obs_t;

  typedef struct {
    logic          act, tk, upd, rs, has_cfg;
    logic [NB-1:0] cs, ce;
    logic [1:0]    cm;
    obs_t          ex;
  } step_t;

  obs_t exp_q[$];
  obs_t obs;
  int   n_pass  = 0;
  int   n_total = 0;

  assign obs = {counter_o, dir_o, end_o, upd_pending_o};

  always #5 clk_i = ~clk_i;

  tcounter_b #(.NUM_BITS(NB)) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .ctrl_active_i (ctrl_active_i),
    .ctrl_update_i (ctrl_update_i),
    .ctrl_rst_i    (ctrl_rst_i),
    .cfg_start_i   (cfg_start_i),
    .cfg_end_i     (cfg_end_i),
    .cfg_mode_i    (cfg_mode_i),
    .tick_i        (tick_i),
    .counter_o     (counter_o),
    .dir_o         (dir_o),
    .end_o         (end_o),
    .upd_pending_o (upd_pending_o)
  );

  function automatic obs_t mk(input int c, input int d, input int e, input int p);
    return {c[NB-1:0], d[0], e[0], p[0]};
  endfunction

  function automatic step_t st(input int act, input int tk, input int upd, input int rs,
                               input obs_t ex);
    step_t s;
    s.act = act[0]; s.tk = tk[0]; s.upd = upd[0]; s.rs = rs[0]; s.has_cfg = 1'b0;
    s.cs = '0; s.ce = '0; s.cm = '0; s.ex = ex;
    return s;
  endfunction

  function automatic step_t stc(input int act, input int tk, input int upd, input int rs,
                                input int cs, input int ce, input int cm, input obs_t ex);
    step_t s;
    s = st(act, tk, upd, rs, ex);
    s.has_cfg = 1'b1; s.cs = cs[NB-1:0]; s.ce = ce[NB-1:0]; s.cm = cm[1:0];
    return s;
  endfunction

  task automatic drive(input step_t s);
    ctrl_active_i = s.act;
    tick_i        = s.tk;
    ctrl_update_i = s.upd;
    ctrl_rst_i    = s.rs;
    if (s.has_cfg) begin
      cfg_start_i = s.cs;
      cfg_end_i   = s.ce;
      cfg_mode_i  = s.cm;
    end
  endtask

  task automatic clear_pulses();
    tick_i        = 1'b0;
    ctrl_update_i = 1'b0;
    ctrl_rst_i    = 1'b0;
  endtask

  task automatic test_reset();
    step_t s[$];
    obs_t  want;
    rstn_i = 1'b1;
    #2 rstn_i = 1'b0;
    #10;
    n_total++;
    if (obs !== '0) $display("FAIL reset_values: got %h want %h", obs, obs_t'(0));
    else n_pass++;
    rstn_i = 1'b1;
    // Reset shadow is start=end=0: an active tick holds 0 and pulses end.
    s.push_back(st(1, 1, 0, 0, mk(0, 0, 1, 0)));
    s.push_back(st(0, 1, 0, 0, mk(0, 0, 0, 0)));
    foreach (s[k]) begin
      drive(s[k]); exp_q.push_back(s[k].ex);
      @(posedge clk_i); #1; clear_pulses();
      want = exp_q.pop_front(); n_total++;
      if (obs !== want)
        $display("FAIL reset[%0d]: got cnt=%h dir=%b end=%b pend=%b want cnt=%h dir=%b end=%b pend=%b",
                 k, obs[NB+2:3], obs[2], obs[1], obs[0], want[NB+2:3], want[2], want[1], want[0]);
      else n_pass++;
    end
  endtask

  task automatic test_up();
    step_t s[$];
    obs_t  want;
    s.push_back(stc(0, 0, 1, 0, 2, 5, 0, mk(0, 0, 0, 1)));
    s.push_back(st(0, 0, 0, 0, mk(2, 0, 0, 0)));
    for (int i = 0; i < 8; i++)
      s.push_back(st(1, 1, 0, 0, mk(2 + (i + 1) % 4, 0, ((i % 4) == 3) ? 1 : 0, 0)));
    s.push_back(st(0, 1, 0, 0, mk(2, 0, 0, 0)));            // inactive tick ignored
    s.push_back(st(1, 0, 0, 0, mk(2, 0, 0, 0)));            // enabling does not reload
    s.push_back(stc(1, 1, 0, 0, 2, 5, 1, mk(3, 0, 0, 0)));  // mode change alone ignored
    foreach (s[k]) begin
      drive(s[k]); exp_q.push_back(s[k].ex);
      @(posedge clk_i); #1; clear_pulses();
      want = exp_q.pop_front(); n_total++;
      if (obs !== want)
        $display("FAIL up[%0d]: got cnt=%h dir=%b end=%b pend=%b want cnt=%h dir=%b end=%b pend=%b",
                 k, obs[NB+2:3], obs[2], obs[1], obs[0], want[NB+2:3], want[2], want[1], want[0]);
      else n_pass++;
    end
  endtask

  task automatic test_updown();
    step_t s[$];
    obs_t  want;
    int    cnt[8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    int    dir[8] = '{0, 0, 0, 1, 1, 1, 0, 0};
    s.push_back(stc(0, 0, 1, 0, 0, 3, 2, mk(3, 0, 0, 1)));
    s.push_back(st(0, 0, 0, 0, mk(0, 0, 0, 0)));
    for (int i = 0; i < 8; i++)
      s.push_back(st(1, 1, 0, 0, mk(cnt[i], dir[i], (i == 6) ? 1 : 0, 0)));
    foreach (s[k]) begin
      drive(s[k]); exp_q.push_back(s[k].ex);
      @(posedge clk_i); #1; clear_pulses();
      want = exp_q.pop_front(); n_total++;
      if (obs !== want)
        $display("FAIL updown[%0d]: got cnt=%h dir=%b end=%b pend=%b want cnt=%h dir=%b end=%b pend=%b",
                 k, obs[NB+2:3], obs[2], obs[1], obs[0], want[NB+2:3], want[2], want[1], want[0]);
      else n_pass++;
    end
  endtask

  task automatic test_update_pending();
    step_t s[$];
    obs_t  want;
    s.push_back(stc(0, 0, 1, 0, 0, 9, 0, mk(2, 0, 0, 1)));
    s.push_back(st(0, 0, 0, 0, mk(0, 0, 0, 0)));
    for (int v = 1; v <= 6; v++) s.push_back(st(1, 1, 0, 0, mk(v, 0, 0, 0)));
    s.push_back(stc(1, 0, 1, 0, 3, 8, 0, mk(6, 0, 0, 1)));
    s.push_back(stc(1, 1, 1, 0, 1, 4, 0, mk(7, 0, 0, 1)));  // overwrites staging
    s.push_back(st(1, 1, 0, 0, mk(8, 0, 0, 1)));
    s.push_back(st(1, 1, 0, 0, mk(9, 0, 0, 1)));
    s.push_back(st(1, 1, 0, 0, mk(1, 0, 1, 0)));            // apply at period end
    for (int v = 2; v <= 4; v++) s.push_back(st(1, 1, 0, 0, mk(v, 0, 0, 0)));
    s.push_back(st(1, 1, 0, 0, mk(1, 0, 1, 0)));
    foreach (s[k]) begin
      drive(s[k]); exp_q.push_back(s[k].ex);
      @(posedge clk_i); #1; clear_pulses();
      want = exp_q.pop_front(); n_total++;
      if (obs !== want)
        $display("FAIL upd_pending[%0d]: got cnt=%h dir=%b end=%b pend=%b want cnt=%h dir=%b end=%b pend=%b",
                 k, obs[NB+2:3], obs[2], obs[1], obs[0], want[NB+2:3], want[2], want[1], want[0]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    step_t s[$];
    obs_t  want;
    s.push_back(stc(0, 0, 1, 0, 'hFFFE, 'h0001, 0, mk(1, 0, 0, 1)));
    s.push_back(st(0, 0, 0, 0, mk('hFFFE, 0, 0, 0)));
    s.push_back(st(1, 1, 0, 0, mk('hFFFF, 0, 0, 0)));
    s.push_back(st(1, 1, 0, 0, mk('h0000, 0, 0, 0)));
    s.push_back(st(1, 1, 0, 0, mk('h0001, 0, 0, 0)));
    s.push_back(st(1, 1, 0, 0, mk('hFFFE, 0, 1, 0)));
    foreach (s[k]) begin
      drive(s[k]); exp_q.push_back(s[k].ex);
      @(posedge clk_i); #1; clear_pulses();
      want = exp_q.pop_front(); n_total++;
      if (obs !== want)
        $display("FAIL wrap[%0d]: got cnt=%h dir=%b end=%b pend=%b want cnt=%h dir=%b end=%b pend=%b",
                 k, obs[NB+2:3], obs[2], obs[1], obs[0], want[NB+2:3], want[2], want[1], want[0]);
      else n_pass++;
    end
  endtask

  task automatic test_down_restart();
    step_t s[$];
    obs_t  want;
    s.push_back(stc(0, 0, 1, 0, 1, 7, 1, mk('hFFFE, 0, 0, 1)));
    s.push_back(st(0, 0, 0, 0, mk(7, 1, 0, 0)));
    for (int v = 6; v >= 4; v--) s.push_back(st(1, 1, 0, 0, mk(v, 1, 0, 0)));
    s.push_back(st(1, 1, 0, 1, mk(7, 1, 0, 0)));             // restart beats tick
    for (int v = 6; v >= 1; v--) s.push_back(st(1, 1, 0, 0, mk(v, 1, 0, 0)));
    s.push_back(st(1, 1, 0, 0, mk(7, 1, 1, 0)));             // down period end
    s.push_back(stc(1, 0, 1, 0, 3, 3, 0, mk(7, 1, 0, 1)));
    for (int v = 6; v >= 1; v--) s.push_back(st(1, 1, 0, 0, mk(v, 1, 0, 1)));
    s.push_back(st(1, 1, 0, 1, mk(7, 1, 0, 1)));             // restart beats apply
    for (int v = 6; v >= 1; v--) s.push_back(st(1, 1, 0, 0, mk(v, 1, 0, 1)));
    s.push_back(st(1, 1, 0, 0, mk(3, 0, 1, 0)));             // apply, new UP origin
    foreach (s[k]) begin
      drive(s[k]); exp_q.push_back(s[k].ex);
      @(posedge clk_i); #1; clear_pulses();
      want = exp_q.pop_front(); n_total++;
      if (obs !== want)
        $display("FAIL down_rst[%0d]: got cnt=%h dir=%b end=%b pend=%b want cnt=%h dir=%b end=%b pend=%b",
                 k, obs[NB+2:3], obs[2], obs[1], obs[0], want[NB+2:3], want[2], want[1], want[0]);
      else n_pass++;
    end
  endtask

  task automatic test_equal_bounds();
    step_t s[$];
    obs_t  want;
    for (int i = 0; i < 4; i++) s.push_back(st(1, 1, 0, 0, mk(3, 0, 1, 0)));
    s.push_back(stc(1, 1, 0, 0, 3, 3, 1, mk(3, 0, 1, 0)));
    s.push_back(stc(1, 0, 1, 0, 5, 9, 1, mk(3, 0, 0, 1)));
    foreach (s[k]) begin
      drive(s[k]); exp_q.push_back(s[k].ex);
      @(posedge clk_i); #1; clear_pulses();
      want = exp_q.pop_front(); n_total++;
      if (obs !== want)
        $display("FAIL equal[%0d]: got cnt=%h dir=%b end=%b pend=%b want cnt=%h dir=%b end=%b pend=%b",
                 k, obs[NB+2:3], obs[2], obs[1], obs[0], want[NB+2:3], want[2], want[1], want[0]);
      else n_pass++;
    end
    // Asynchronous reset between clock edges.
    #2 rstn_i = 1'b0;
    #1;
    n_total++;
    if (obs !== '0) $display("FAIL async_reset: got %h want %h", obs, obs_t'(0));
    else n_pass++;
    #2 rstn_i = 1'b1;
    s.delete();
    s.push_back(st(1, 1, 0, 0, mk(0, 0, 1, 0)));             // shadow back to 0/0
    s.push_back(st(0, 0, 0, 0, mk(0, 0, 0, 0)));             // staging cleared, nothing applies
    foreach (s[k]) begin
      drive(s[k]); exp_q.push_back(s[k].ex);
      @(posedge clk_i); #1; clear_pulses();
      want = exp_q.pop_front(); n_total++;
      if (obs !== want)
        $display("FAIL after_areset[%0d]: got cnt=%h dir=%b end=%b pend=%b want cnt=%h dir=%b end=%b pend=%b",
                 k, obs[NB+2:3], obs[2], obs[1], obs[0], want[NB+2:3], want[2], want[1], want[0]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_up();
    test_updown();
    test_update_pending();
    test_wrap();
    test_down_restart();
    test_equal_bounds();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
